// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
//   Two-stage pipelined execute stage for the RV32I shift instructions
//   (SLL/SRL/SRA and their immediate forms).
//   Stage 1 decodes and registers the operands. Its registers drive the ALU's
//   combinational logical shifter (Left_Right_shifter). Stage 2 ORs in the
//   sign fill for arithmetic right shifts, because the shifter only does
//   logical shifts. It then holds the result until writeback takes it.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/ready    upstream handshake (in_ready is combinational)
//   in_rs1            value to be shifted
//   in_rs2            register shift amount (bits [4:0] used)
//   in_shamt          immediate shift amount
//   in_use_imm        1 selects in_shamt, 0 selects in_rs2[4:0]
//   in_funct3         001 left, 101 right; anything else is illegal
//   in_funct7_b5      instr[30]: arithmetic right shift, illegal with SLL
//   in_rd             destination tag, passed through
//   out_valid/ready   downstream handshake
//   out_result        shift result (0 for illegal ops)
//   out_rd            tag of out_result
//   out_illegal       operation was not a legal shift
//   op_count          saturating count of completed output transfers
// -----------------------------------------------------------------------------

// Combinational logical left/right shifter of the ALU (no sign fill).
module Left_Right_shifter (
  input  logic [31:0] i_data,
  input  logic [4:0]  i_shamt,
  input  logic        i_shift_direction,  // 1 = left, 0 = right
  output logic [31:0] o_data
);
  assign o_data = i_shift_direction ? (i_data << i_shamt) : (i_data >> i_shamt);
endmodule

module shift_exec_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [4:0]       in_shamt,
  input  logic             in_use_imm,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_b5,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  // Stage 1 registers
  logic        r_s1_valid;
  logic [31:0] r_a;
  logic [4:0]  r_n;
  logic        r_dir;
  logic        r_arith;
  logic        r_illegal;
  logic [4:0]  r_rd;

  // Stage 2 registers
  logic             r_s2_valid;
  logic [31:0]      r_result;
  logic [4:0]       r_out_rd;
  logic             r_out_illegal;
  logic [CNT_W-1:0] r_op_count;

  // Decode of the incoming operation
  logic [4:0] w_dec_n;
  logic       w_dec_dir;
  logic       w_dec_arith;
  logic       w_dec_illegal;
  logic       w_unused_rs2;

  assign w_dec_n       = in_use_imm ? in_shamt : in_rs2[4:0];
  assign w_dec_dir     = (in_funct3 == 3'b001);
  assign w_dec_arith   = (in_funct3 == 3'b101) & in_funct7_b5;
  assign w_dec_illegal = !(((in_funct3 == 3'b001) & !in_funct7_b5) | (in_funct3 == 3'b101));
  assign w_unused_rs2  = ^in_rs2[31:5];

  // Handshake. Stage 2 can take the stage-1 op when it is empty or is being
  // drained this cycle. Stage 1 can take a new op when it is empty or is
  // moving into stage 2, so a full pipe still streams one op per cycle.
  logic w_s2_load;
  logic w_out_xfer;

  assign w_s2_load  = r_s1_valid & (!r_s2_valid | out_ready);
  assign w_out_xfer = r_s2_valid & out_ready;
  assign in_ready   = !r_s1_valid | w_s2_load;

  // Shifter driven from the stage-1 registers
  logic [31:0] w_shift;
  logic [31:0] w_fill;
  logic [31:0] w_result;

  Left_Right_shifter u_shifter (
    .i_data            (r_a),
    .i_shamt           (r_n),
    .i_shift_direction (r_dir),
    .o_data            (w_shift)
  );

  // Ones in the top n bit positions. These are the bits a logical right
  // shift zero-filled. Setting them turns it into an arithmetic shift.
  assign w_fill = ~(32'hFFFF_FFFF >> r_n);

  always_comb begin
    w_result = w_shift;
    if (r_illegal) begin
      w_result = 32'h0;
    end else if (r_arith && r_a[31]) begin
      w_result = w_shift | w_fill;
    end
  end

  // Stage 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= 32'h0;
      r_n        <= 5'h0;
      r_dir      <= 1'b0;
      r_arith    <= 1'b0;
      r_illegal  <= 1'b0;
      r_rd       <= 5'h0;
    end else if (in_ready) begin
      // Either empty or advancing. It takes whatever is offered, which may be nothing.
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_a       <= in_rs1;
        r_n       <= w_dec_n;
        r_dir     <= w_dec_dir;
        r_arith   <= w_dec_arith;
        r_illegal <= w_dec_illegal;
        r_rd      <= in_rd;
      end
    end
  end

  // Stage 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid    <= 1'b0;
      r_result      <= 32'h0;
      r_out_rd      <= 5'h0;
      r_out_illegal <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid    <= 1'b1;
      r_result      <= w_result;
      r_out_rd      <= r_rd;
      r_out_illegal <= r_illegal;
    end else if (w_out_xfer) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Completed-operation counter, sticks at all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_out_xfer && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_result  = r_result;
  assign out_rd      = r_out_rd;
  assign out_illegal = r_out_illegal;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage. A queue-based reference model computes every
// expected result straight from the instruction semantics. A narrow counter
// makes saturation reachable.
module tb_shift_exec_stage;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_use_imm, in_funct7_b5;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0] in_shamt, in_rd;
  logic [2:0] in_funct3;
  logic out_valid, out_ready, out_illegal;
  logic [31:0] out_result;
  logic [4:0] out_rd;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  shift_exec_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_shamt(in_shamt),
    .in_use_imm(in_use_imm), .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
    .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal),
    .op_count(op_count)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  // Values sampled by cycle() at the falling edge
  logic s_in_xfer, s_out_xfer, s_in_ready, s_out_valid, s_have_exp;
  logic [31:0] s_res;
  logic [4:0] s_rd;
  logic s_ill;
  exp_t s_exp;

  function automatic exp_t model(logic [31:0] a, logic [31:0] rs2, logic [4:0] sh,
                                 logic ui, logic [2:0] f3, logic f7, logic [4:0] rd);
    exp_t e;
    logic [4:0] n;
    n = ui ? sh : rs2[4:0];
    e.rd = rd;
    e.ill = 1'b0;
    if (f3 == 3'b001 && !f7) e.res = a << n;
    else if (f3 == 3'b101 && f7) e.res = $signed(a) >>> n;
    else if (f3 == 3'b101) e.res = a >> n;
    else begin
      e.res = 32'h0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Sample the DUT at negedge, update the model on the transfers that will
  // happen at the coming rising edge, then return 1 time unit after that edge.
  task automatic cycle();
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_in_xfer   = in_valid && in_ready;
    s_out_xfer  = out_valid && out_ready;
    s_res = out_result;
    s_rd = out_rd;
    s_ill = out_illegal;
    s_have_exp = 1'b0;
    if (s_in_xfer)
      q.push_back(model(in_rs1, in_rs2, in_shamt, in_use_imm, in_funct3, in_funct7_b5, in_rd));
    if (s_out_xfer) begin
      if (q.size() > 0) begin
        s_exp = q.pop_front();
        s_have_exp = 1'b1;
      end
      if (exp_count < MAXC) exp_count++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(logic [31:0] a, logic [31:0] rs2, logic [4:0] sh, logic ui,
                        logic [2:0] f3, logic f7, logic [4:0] rd);
    in_rs1 = a; in_rs2 = rs2; in_shamt = sh; in_use_imm = ui;
    in_funct3 = f3; in_funct7_b5 = f7; in_rd = rd; in_valid = 1'b1;
  endtask

  task automatic set_random_op();
    logic [2:0] f3;
    case ($urandom_range(0, 4))
      0, 1:    f3 = 3'b001;
      2, 3:    f3 = 3'b101;
      default: f3 = 3'($urandom);
    endcase
    set_op($urandom, $urandom, 5'($urandom), 1'($urandom), f3,
           (f3 == 3'b001) ? ($urandom_range(0, 9) == 0) : 1'($urandom), 5'($urandom));
    // Bias toward the shift-amount corners
    if ($urandom_range(0, 3) == 0) begin
      in_shamt = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
      in_rs2[4:0] = in_shamt;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_op(0, 0, 0, 0, 3'b001, 0, 0); in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 ||
        out_rd !== 5'h0 || out_illegal !== 1'b0 || op_count !== '0) begin
      errors++;
      $display("FAIL reset: out_valid=%b in_ready=%b result=%h rd=%h ill=%b cnt=%0d, required 0 1 0 0 0 0",
               out_valid, in_ready, out_result, out_rd, out_illegal, op_count);
    end
    rst = 1'b0;
    q.delete(); exp_count = 0;
    $display("reset: checked idle state");
  endtask

  task automatic test_slli();
    out_ready = 1'b1;
    set_op(32'h0000_0001, 32'h0, 5'd31, 1'b1, 3'b001, 1'b0, 5'd7);
    cycle();
    in_valid = 1'b0;
    cycle();
    checks++;
    if (!s_in_ready || s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL slli_latency: out_valid=%b one edge after accept, required 0", s_out_valid);
    end
    cycle();
    checks++;
    if (!s_out_xfer || !s_have_exp || s_res !== 32'h8000_0000 || s_ill !== 1'b0 ||
        s_rd !== 5'd7 || s_res !== s_exp.res) begin
      errors++;
      $display("FAIL slli: valid=%b result=%h ill=%b rd=%0d, required 1 80000000 0 7",
               s_out_valid, s_res, s_ill, s_rd);
    end
    $display("slli: result=%h rd=%0d", s_res, s_rd);
  endtask

  task automatic test_sra();
    logic [31:0] want [2];
    int got;
    want[0] = 32'hFF00_0000;
    want[1] = 32'h0F00_0000;
    got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12 && got < 2; i++) begin
      if (i == 0) set_op(32'hF000_0000, 32'h0000_0024, 5'd17, 1'b0, 3'b101, 1'b1, 5'd1);
      else if (i == 1) set_op(32'hF000_0000, 32'h0000_0024, 5'd17, 1'b0, 3'b101, 1'b0, 5'd2);
      else in_valid = 1'b0;
      cycle();
      if (s_out_xfer) begin
        checks++;
        if (!s_have_exp || s_res !== want[got] || s_res !== s_exp.res || s_ill !== 1'b0) begin
          errors++;
          $display("FAIL sra_%0d: result=%h, required %h", got, s_res, want[got]);
        end
        $display("sra: op %0d result=%h", got, s_res);
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL sra_timeout: outputs=%0d, required 2", got);
    end
  endtask

  task automatic test_back_to_back();
    int got, start;
    got = 0;
    start = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && got < 8; i++) begin
      if (i < 8) set_random_op(); else in_valid = 1'b0;
      cycle();
      if (i < 8) begin
        checks++;
        if (s_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready: cycle %0d in_ready=%b, required 1", i, s_in_ready);
        end
      end
      if (got > 0 && !s_out_valid) begin
        checks++; errors++;
        $display("FAIL b2b_gap: out_valid=0 after %0d outputs, required 1", got);
      end
      if (s_out_xfer) begin
        checks++;
        if (!s_have_exp || s_res !== s_exp.res || s_rd !== s_exp.rd || s_ill !== s_exp.ill) begin
          errors++;
          $display("FAIL b2b_data: result=%h rd=%0d ill=%b, required %h %0d %b",
                   s_res, s_rd, s_ill, s_exp.res, s_exp.rd, s_exp.ill);
        end
        if (start < 0) start = i;
        $display("b2b: out %0d result=%h rd=%0d", got, s_res, s_rd);
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 8 || start != 2 || op_count !== CNT_W'(exp_count)) begin
      errors++;
      $display("FAIL b2b_summary: outputs=%0d first=%0d cnt=%0d, required 8 2 %0d",
               got, start, op_count, exp_count);
    end
  endtask

  task automatic test_backpressure();
    int acc, got;
    logic seen;
    logic [31:0] hold_res;
    logic [4:0] hold_rd;
    logic hold_ill;
    acc = 0; got = 0; seen = 1'b0;
    hold_res = '0; hold_rd = '0; hold_ill = 1'b0;
    out_ready = 1'b0;
    set_random_op();
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (s_in_xfer) begin
        acc++;
        set_random_op();
      end
      if (s_out_valid) begin
        if (seen) begin
          checks++;
          if (s_res !== hold_res || s_rd !== hold_rd || s_ill !== hold_ill) begin
            errors++;
            $display("FAIL bp_stable: result=%h rd=%0d ill=%b, required %h %0d %b",
                     s_res, s_rd, s_ill, hold_res, hold_rd, hold_ill);
          end
        end
        seen = 1'b1;
        hold_res = s_res; hold_rd = s_rd; hold_ill = s_ill;
      end
    end
    checks++;
    if (acc != 2 || s_in_ready !== 1'b0 || !seen) begin
      errors++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 2 0", acc, s_in_ready);
    end
    $display("bp: accepted %0d under stall", acc);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && got < 3; i++) begin
      cycle();
      if (s_in_xfer) begin
        acc++;
        in_valid = 1'b0;
      end
      if (s_out_xfer) begin
        checks++;
        if (!s_have_exp || s_res !== s_exp.res || s_rd !== s_exp.rd || s_ill !== s_exp.ill) begin
          errors++;
          $display("FAIL bp_data: result=%h rd=%0d, required %h %0d",
                   s_res, s_rd, s_exp.res, s_exp.rd);
        end
        $display("bp: out %0d result=%h rd=%0d", got, s_res, s_rd);
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 3 || acc != 3) begin
      errors++;
      $display("FAIL bp_drain: outputs=%0d accepted=%0d, required 3 3", got, acc);
    end
  endtask

  task automatic test_illegal();
    int got;
    got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12 && got < 3; i++) begin
      if (i == 0) set_op(32'hDEAD_BEEF, 32'h3, 5'd3, 1'b0, 3'b000, 1'b0, 5'd9);
      else if (i == 1) set_op(32'h1234_5678, 32'h0, 5'd4, 1'b1, 3'b001, 1'b1, 5'd10);
      else if (i == 2) set_op(32'hFFFF_0000, 32'h0, 5'd1, 1'b1, 3'b110, 1'b1, 5'd11);
      else in_valid = 1'b0;
      cycle();
      if (s_out_xfer) begin
        checks++;
        if (!s_have_exp || s_res !== 32'h0 || s_ill !== 1'b1 || s_rd !== s_exp.rd ||
            op_count !== CNT_W'(exp_count)) begin
          errors++;
          $display("FAIL illegal_%0d: result=%h ill=%b cnt=%0d, required 0 1 %0d",
                   got, s_res, s_ill, op_count, exp_count);
        end
        $display("illegal: out %0d ill=%b rd=%0d", got, s_ill, s_rd);
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 3) begin
      errors++;
      $display("FAIL illegal_timeout: outputs=%0d, required 3", got);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    set_random_op();
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (s_in_xfer) set_random_op();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    checks++;
    if (op_count !== CNT_W'(MAXC) || q.size() != 0) begin
      errors++;
      $display("FAIL saturation: cnt=%0d pending=%0d, required %0d 0", op_count, q.size(), MAXC);
    end
    $display("saturation: op_count=%0d", op_count);
  endtask

  task automatic test_random();
    logic stalled;
    logic [31:0] hold_res;
    logic [4:0] hold_rd;
    logic hold_ill;
    stalled = 1'b0;
    hold_res = '0; hold_rd = '0; hold_ill = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!in_valid || s_in_xfer) begin
        if ($urandom_range(0, 3) != 0) set_random_op(); else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
      if (stalled && s_out_valid) begin
        checks++;
        if (s_res !== hold_res || s_rd !== hold_rd || s_ill !== hold_ill) begin
          errors++;
          $display("FAIL rand_stable: result=%h rd=%0d, required %h %0d", s_res, s_rd, hold_res, hold_rd);
        end
      end
      stalled = s_out_valid && !s_out_xfer;
      hold_res = s_res; hold_rd = s_rd; hold_ill = s_ill;
      if (s_out_xfer) begin
        checks++;
        if (!s_have_exp || s_res !== s_exp.res || s_rd !== s_exp.rd || s_ill !== s_exp.ill) begin
          errors++;
          $display("FAIL rand_data: result=%h rd=%0d ill=%b, required %h %0d %b",
                   s_res, s_rd, s_ill, s_exp.res, s_exp.rd, s_exp.ill);
        end
        $display("rand: result=%h rd=%0d ill=%b", s_res, s_rd, s_ill);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_out_xfer) begin
        checks++;
        if (!s_have_exp || s_res !== s_exp.res || s_rd !== s_exp.rd || s_ill !== s_exp.ill) begin
          errors++;
          $display("FAIL rand_drain: result=%h rd=%0d, required %h %0d", s_res, s_rd, s_exp.res, s_exp.rd);
        end
        $display("rand: drain result=%h rd=%0d", s_res, s_rd);
      end
    end
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0 || op_count !== CNT_W'(exp_count)) begin
      errors++;
      $display("FAIL rand_end: pending=%0d out_valid=%b cnt=%0d, required 0 0 %0d",
               q.size(), out_valid, op_count, exp_count);
    end
  endtask

  task automatic test_reset_midflight();
    int got;
    got = 0;
    out_ready = 1'b0;
    set_random_op();
    cycle();
    set_random_op();
    cycle();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || op_count !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: out_valid=%b cnt=%0d in_ready=%b, required 0 0 1",
               out_valid, op_count, in_ready);
    end
    q.delete(); exp_count = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    set_op(32'h8000_0001, 32'h1F, 5'd0, 1'b0, 3'b101, 1'b1, 5'd21);
    cycle();
    checks++;
    if (!s_in_xfer) begin
      errors++;
      $display("FAIL reset_first_accept: in_ready=%b on first edge after reset, required 1", s_in_ready);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_out_xfer) begin
        checks++;
        if (!s_have_exp || s_res !== 32'hFFFF_FFFF || s_rd !== 5'd21) begin
          errors++;
          $display("FAIL reset_stale: result=%h rd=%0d, required ffffffff 21", s_res, s_rd);
        end
        $display("reset_mid: post-reset result=%h rd=%0d", s_res, s_rd);
        got++;
      end
    end
    checks++;
    if (got != 1 || op_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL reset_outputs: outputs=%0d cnt=%0d, required 1 1", got, op_count);
    end
  endtask

  initial begin
    test_reset();
    test_slli();
    test_sra();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_saturation();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
